dtu_wbuf: RTL

DTU_WBUF -- requirements
Module: dtu_wbuf

---
 rtl/dtu_wbuf.sv | 80 ++++++++
 1 files changed

// File: rtl/dtu_wbuf.sv
// dtu_wbuf: write buffer that merges loader and core writes into a FIFO and drains it to memory.
// Optional DTU_ADDR_CHECK_EN drops out-of-range core writes and flags them on sticky addr_err.
module dtu_wbuf #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int CPU_ADDR_W = 8,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_valid,
    input  logic [ADDR_W-1:0]         ld_addr,
    input  logic [DATA_W-1:0]         ld_data,
    output logic                      ld_ready,
    input  logic                      cpu_valid,
    input  logic [CPU_ADDR_W-1:0]     cpu_addr,
    input  logic [DATA_W-1:0]         cpu_data,
    output logic                      cpu_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
`ifdef DTU_ADDR_CHECK_EN
    output logic                      addr_err,
`endif
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_W + DATA_W;

    logic [EW-1:0] store [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [EW-1:0] wr_entry;
    logic          push, pop, cpu_fire;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    // ready is derived from pre-pop occupancy, so a full buffer never accepts
    assign ld_ready  = !full;
    assign cpu_ready = !full && !ld_valid;
    assign cpu_fire  = cpu_valid && cpu_ready;
    assign pop       = !empty && mem_ready;
    assign wr_entry  = ld_valid ? {ld_addr, ld_data} : {cpu_addr[ADDR_W-1:0], cpu_data};
    assign mem_we    = !empty;
    assign {mem_addr, mem_wdata} = empty ? '0 : store[rd_ptr];

`ifdef DTU_ADDR_CHECK_EN
    logic addr_bad;
    assign addr_bad = (cpu_addr >> ADDR_W) != '0;
    assign push     = (ld_valid && ld_ready) || (cpu_fire && !addr_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 addr_err <= 1'b0;
        else if (cpu_fire && addr_bad) addr_err <= 1'b1;
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^(cpu_addr >> ADDR_W);
    assign push           = (ld_valid && ld_ready) || cpu_fire;
`endif

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule
